seq_scan_arb: RTL and testbench

Two-requester front end for the team's bit-serial Mealy pattern detector. Arbitrates round-robin between two sources offering W-bit words. Shifts the granted word MSB-first through an internal overlapping-match detector and returns a per-bit hit mask and hit count through a valid/ready result port. Sits between the parallel word producers and the result consumer, so the serial detector can be shared without a per-source copy.

---
 rtl/seq_ctrl_pkg.sv | 18 +
 rtl/seq_det_core.sv | 41 ++++
 rtl/seq_scan_arb.sv | 108 ++++++++++
 tb/tb_seq_scan_arb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared encodings and defaults for the serial scan arbiter.
// Imported by the arbiter top and the detector core.
package seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int         DEF_PLEN    = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1011;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_det_core.sv
// Bit-serial Mealy detector with overlapping matches.
// The fill counter keeps a freshly cleared history from matching.
module seq_det_core
    import seq_ctrl_pkg::*;
#(
    parameter int              PLEN    = DEF_PLEN,
    parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic match
);

    localparam int            FW   = $clog2(PLEN);
    localparam logic [FW-1:0] FMAX = FW'(PLEN - 1);

    logic [PLEN-2:0] hist;
    logic [FW-1:0]   fill;
    logic [PLEN-1:0] win;

    assign win   = {hist, bit_in};
    assign match = (fill == FMAX) && (win == PATTERN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= win[PLEN-2:0];
            if (fill != FMAX)
                fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/seq_scan_arb.sv
// Round-robin front end sharing one serial detector between two
// word sources; returns a per-bit hit mask over valid/ready.
module seq_scan_arb
    import seq_ctrl_pkg::*;
#(
    parameter int              W       = 8,
    parameter int              PLEN    = DEF_PLEN,
    parameter logic [PLEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [W-1:0]          data0,
    input  logic [W-1:0]          data1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_src,
    output logic [W-1:0]          res_hits,
    output logic [cnt_w(W)-1:0]   res_count,
    output logic                  busy
);

    localparam int IW = $clog2(W);
    localparam int CW = cnt_w(W);

    state_t        state;
    logic          ptr;
    logic [W-1:0]  word;
    logic [IW-1:0] idx;
    logic          bit_in;
    logic          match;
    logic          det_en;
    logic          det_clr;

    // Grants are masked while reset is held so they read 0 in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst && state == IDLE) begin
            gnt0 = req0 && (!ptr || !req1);
            gnt1 = req1 && (ptr || !req0);
        end
    end

    assign bit_in    = word[idx];
    assign det_en    = (state == SHIFT);
    assign det_clr   = gnt0 | gnt1;
    assign busy      = (state != IDLE);
    assign res_valid = (state == RESP);

    always_comb begin
        res_count = '0;
        for (int i = 0; i < W; i++)
            res_count = res_count + CW'(res_hits[i]);
    end

    seq_det_core #(
        .PLEN    (PLEN),
        .PATTERN (PATTERN)
    ) u_det (
        .clk    (clk),
        .rst    (rst),
        .clr    (det_clr),
        .en     (det_en),
        .bit_in (bit_in),
        .match  (match)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            word     <= '0;
            idx      <= '0;
            res_src  <= 1'b0;
            res_hits <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        word     <= gnt1 ? data1 : data0;
                        res_src  <= gnt1;
                        res_hits <= '0;
                        idx      <= IW'(W - 1);
                        ptr      <= gnt0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_hits[idx] <= res_hits[idx] | match;
                    if (idx == '0)
                        state <= RESP;
                    else
                        idx <= idx - 1'b1;
                end
                RESP: begin
                    if (res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_arb.sv
// Self-checking bench for seq_scan_arb: vector table, hand-written
// corner sequences and randomized traffic against a word-level model.
module tb_seq_scan_arb;

    localparam int         W   = 8;
    localparam int         PL  = 4;
    localparam logic [3:0] PAT = 4'b1011;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0 = 1'b0;
    logic         req1 = 1'b0;
    logic [W-1:0] data0 = '0;
    logic [W-1:0] data1 = '0;
    logic         gnt0, gnt1;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic         res_src;
    logic [W-1:0] res_hits;
    logic [3:0]   res_count;
    logic         busy;

    int   vecs = 0;
    int   errs = 0;
    logic ptr_m = 1'b0;

    seq_scan_arb #(.W(W), .PLEN(PL), .PATTERN(PAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .data0     (data0),
        .data1     (data1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_src   (res_src),
        .res_hits  (res_hits),
        .res_count (res_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         r0;
        logic         r1;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic         es;
        logic [W-1:0] eh;
        logic [3:0]   ec;
        int           stall;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Match ends at bit i when the PL bits starting at i equal the pattern.
    function automatic logic [W-1:0] ref_hits(input logic [W-1:0] w);
        logic [W-1:0] h;
        h = '0;
        for (int i = 0; i <= W - PL; i++)
            if (4'(w >> i) == PAT)
                h[i] = 1'b1;
        return h;
    endfunction

    function automatic logic winner();
        if (req0 && req1)
            return ptr_m;
        return req1;
    endfunction

    // Entered at a clock-low point of an IDLE cycle with requests applied.
    task automatic serve(input logic es, input logic [W-1:0] eh,
                         input logic [3:0] ec, input int stall);
        chk("grant", {busy, gnt0, gnt1}, {1'b0, !es, es});
        ptr_m = !es;
        @(posedge clk);
        #1;
        if (es)
            req1 = 1'b0;
        else
            req0 = 1'b0;
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            chk("shift", {res_valid, gnt0, gnt1, busy}, 4'b0001);
            res_ready = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("res_valid", {31'd0, res_valid}, 32'd1);
        chk("res_src", {31'd0, res_src}, {31'd0, es});
        chk("res_hits", {24'd0, res_hits}, {24'd0, eh});
        chk("res_count", {28'd0, res_count}, {28'd0, ec});
        res_ready = (stall == 0);
        for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            chk("hold", {res_valid, busy, gnt0, gnt1, res_src, res_hits,
                         res_count}, {4'b1100, es, eh, ec});
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk("accept", {30'd0, busy, res_valid}, 32'd0);
    endtask

    initial begin
        logic         w;
        logic [W-1:0] d;

        tbl[0] = '{1, 0, 8'hB6, 8'h00, 0, 8'h12, 4'd2, 0};
        tbl[1] = '{0, 1, 8'h00, 8'hBB, 1, 8'h11, 4'd2, 0};
        tbl[2] = '{1, 0, 8'h05, 8'h00, 0, 8'h00, 4'd0, 0};
        tbl[3] = '{1, 0, 8'h80, 8'h00, 0, 8'h00, 4'd0, 1};
        tbl[4] = '{0, 1, 8'h00, 8'h0B, 1, 8'h01, 4'd1, 2};
        tbl[5] = '{1, 0, 8'hDB, 8'h00, 0, 8'h09, 4'd2, 0};

        req0 = 1'b1;
        #3;
        chk("reset_out", {gnt0, gnt1, res_valid, res_src, res_hits,
                          res_count, busy}, 32'd0);
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Simultaneous requests alternate, source 0 first.
        req0 = 1'b1; req1 = 1'b1;
        data0 = 8'hB6; data1 = 8'hBB;
        #1;
        serve(1'b0, 8'h12, 4'd2, 0);
        serve(1'b1, 8'h11, 4'd2, 0);
        req0 = 1'b1; req1 = 1'b1;
        data0 = 8'h0B; data1 = 8'hB0;
        #1;
        serve(1'b0, 8'h01, 4'd1, 0);
        serve(1'b1, 8'h10, 4'd1, 0);

        for (int i = 0; i < 6; i++) begin
            req0 = tbl[i].r0; req1 = tbl[i].r1;
            data0 = tbl[i].d0; data1 = tbl[i].d1;
            #1;
            serve(tbl[i].es, tbl[i].eh, tbl[i].ec, tbl[i].stall);
        end

        // Long stall with the other source waiting.
        req0 = 1'b1; req1 = 1'b1;
        data0 = 8'hDB; data1 = 8'h2D;
        #1;
        w = winner();
        d = w ? data1 : data0;
        serve(w, ref_hits(d), 4'($countones(ref_hits(d))), 5);
        w = winner();
        d = w ? data1 : data0;
        serve(w, ref_hits(d), 4'($countones(ref_hits(d))), 0);

        // Reset during SHIFT cycle 4 drops the word.
        req0 = 1'b1; data0 = 8'hB6;
        #1;
        chk("rst_gnt", {30'd0, gnt0, gnt1}, 32'd2);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        req1 = 1'b1;
        #1;
        chk("rst_async", {res_valid, busy, gnt0, gnt1, res_hits,
                          res_count}, 32'd0);
        ptr_m = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req0 = 1'b1; data0 = 8'hFF;
        #1;
        serve(1'b0, 8'h00, 4'd0, 0);

        for (int n = 0; n < 40; n++) begin
            if (!req0 && !req1) begin
                case ($urandom_range(0, 2))
                    0: req0 = 1'b1;
                    1: req1 = 1'b1;
                    default: begin
                        req0 = 1'b1;
                        req1 = 1'b1;
                    end
                endcase
                if (req0) data0 = 8'($urandom);
                if (req1) data1 = 8'($urandom);
            end else if (!req0 && $urandom_range(0, 1) == 1) begin
                req0 = 1'b1;
                data0 = 8'($urandom);
            end else if (!req1 && $urandom_range(0, 1) == 1) begin
                req1 = 1'b1;
                data1 = 8'($urandom);
            end
            #1;
            w = winner();
            d = w ? data1 : data0;
            serve(w, ref_hits(d), 4'($countones(ref_hits(d))),
                  int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
